// File: rtl/video_line_fetch.sv
// video_line_fetch: line-buffer fetch, horizontal scaling, border substitution
// and 256x12 palette lookup feeding the 640x480 VGA timing stage.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   start_of_line       strobe on the last clock of each line
//   start_of_screen     coincident with the start_of_line before visible line 0
//   hscale              source columns per output pixel, unsigned 1.7
//   border_color        palette index shown for border / blank pixels
//   lb_rd_addr          line-buffer read address {bank, column}
//   lb_rd_data          line-buffer data, one clock after the address
//   render_bank         bank the renderer fills (inverse of displayed bank)
//   pal_wr_en/addr/data palette write port (read-first on collision)
//   palette_rgb_data    RGB 4:4:4, pixel n valid at T+3+n (T = start_of_line)
//   hscroll             (VIDEO_HSCROLL_EN only) starting source column
//
// Optional feature macro: VIDEO_HSCROLL_EN (horizontal scroll with wrap).
module video_line_fetch #(
  parameter int H_ACTIVE  = 640,
  parameter int SRC_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_of_line,
  input  logic             start_of_screen,
  input  logic [7:0]       hscale,
  input  logic [7:0]       border_color,
`ifdef VIDEO_HSCROLL_EN
  input  logic [9:0]       hscroll,
`endif
  output logic [COL_W:0]   lb_rd_addr,
  input  logic [7:0]       lb_rd_data,
  output logic             render_bank,
  input  logic             pal_wr_en,
  input  logic [7:0]       pal_wr_addr,
  input  logic [11:0]      pal_wr_data,
  output logic [11:0]      palette_rgb_data
);

  localparam int CNT_W = $clog2(H_ACTIVE);
  localparam logic [10:0] SRC_LIM = 11'(SRC_WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [16:0]       pos;        // 10.7 source position of pixel in lb_rd_addr
  logic              bank;       // displayed bank
  logic              bank_fresh; // first line after reset shows bank 0
  logic              brd1, brd2; // border flag, aligned with address / data
  logic [11:0]       pal_mem [256];

  logic [16:0] pos_sum, pos_inc, pos_load;
  logic [9:0]  col_inc, col_load;
  logic        bank_nxt;
  logic [7:0]  rd_idx;

  always_comb begin
    pos_sum = pos + {9'b0, hscale};
    pos_inc = pos_sum;
`ifdef VIDEO_HSCROLL_EN
    // hscale < 2.0, so one subtraction keeps the column inside the source
    if ({1'b0, pos_sum[16:7]} >= SRC_LIM)
      pos_inc = pos_sum - {SRC_LIM[9:0], 7'b0};
    pos_load = {10'({1'b0, hscroll} % SRC_LIM), 7'b0};
`else
    pos_load = '0;
`endif
    col_inc  = pos_inc[16:7];
    col_load = pos_load[16:7];
    bank_nxt = bank;
    if (start_of_line)
      bank_nxt = start_of_screen ? 1'b1 : (bank_fresh ? 1'b0 : ~bank);
    // stage 2: border pixels index the palette with border_color
    rd_idx = brd2 ? border_color : lb_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pos         <= '0;
      bank        <= 1'b0;
      bank_fresh  <= 1'b1;
      render_bank <= 1'b1;
      lb_rd_addr  <= '0;
      brd1        <= 1'b1;
      brd2        <= 1'b1;
    end else begin
      bank        <= bank_nxt;
      render_bank <= ~bank_nxt;
      brd2        <= brd1;
      if (start_of_line) begin
        // also restarts a line in progress
        bank_fresh <= 1'b0;
        state      <= ACTIVE;
        cnt        <= '0;
        pos        <= pos_load;
        lb_rd_addr <= {bank_nxt, col_load[COL_W-1:0]};
        brd1       <= ({1'b0, col_load} >= SRC_LIM);
      end else if (state == ACTIVE) begin
        pos        <= pos_inc;
        lb_rd_addr <= {bank, col_inc[COL_W-1:0]};
        if (cnt == CNT_W'(H_ACTIVE - 1)) begin
          state <= IDLE;
          brd1  <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          brd1 <= ({1'b0, col_inc} >= SRC_LIM);
        end
      end else begin
        brd1 <= 1'b1;
      end
    end
  end

  // Palette contents are not reset; write and read in separate NBA blocks
  // give read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (pal_wr_en) pal_mem[pal_wr_addr] <= pal_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) palette_rgb_data <= '0;
    else     palette_rgb_data <= pal_mem[rd_idx];
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Self-checking bench for video_line_fetch: two instances (full-width source
// and a 300-column source) share stimulus; expected values come from a
// per-pixel arithmetic model of the line fetch.
module tb_video_line_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_of_line, start_of_screen;
  logic [7:0]  hscale, border_color;
  logic [10:0] addr_a, addr_b;
  logic [7:0]  rd_a, rd_b;
  logic        rb_a, rb_b;
  logic        pal_wr_en;
  logic [7:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic [11:0] rgb_a, rgb_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  lb    [2048];
  logic [11:0] pal_m [256];
  logic        bank_m;
  logic        fresh_m;

  always #5 clk = ~clk;

  video_line_fetch #(.H_ACTIVE(640), .SRC_WIDTH(640), .COL_W(10)) dut_a (
    .clk(clk), .rst(rst), .start_of_line(start_of_line),
    .start_of_screen(start_of_screen), .hscale(hscale),
    .border_color(border_color), .lb_rd_addr(addr_a), .lb_rd_data(rd_a),
    .render_bank(rb_a), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .palette_rgb_data(rgb_a));

  video_line_fetch #(.H_ACTIVE(640), .SRC_WIDTH(300), .COL_W(10)) dut_b (
    .clk(clk), .rst(rst), .start_of_line(start_of_line),
    .start_of_screen(start_of_screen), .hscale(hscale),
    .border_color(border_color), .lb_rd_addr(addr_b), .lb_rd_data(rd_b),
    .render_bank(rb_b), .pal_wr_en(pal_wr_en), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .palette_rgb_data(rgb_b));

  // external synchronous line-buffer RAM, one port per instance
  always @(posedge clk) begin
    rd_a <= lb[addr_a];
    rd_b <= lb[addr_b];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // source column of output pixel n: n*hscale in 10.7 fixed point, mod 2^17
  function automatic int col_of(input int n, input int hs);
    return ((n * hs) % 131072) >> 7;
  endfunction

  function automatic logic [11:0] rgb_of(input int n, input int hs, input int src,
                                         input logic bk, input logic [7:0] bc);
    int c;
    c = col_of(n, hs);
    if (c >= src) return pal_m[bc];
    return pal_m[lb[{bk, 10'(c)}]];
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pal_write(input logic [7:0] a, input logic [11:0] d);
    pal_wr_en = 1'b1; pal_wr_addr = a; pal_wr_data = d;
    tick();
    pal_wr_en = 1'b0;
    pal_m[a] = d;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr_a"}, 16'(addr_a), 16'h0);
    chk({tag, "_addr_b"}, 16'(addr_b), 16'h0);
    chk({tag, "_rgb_a"},  16'(rgb_a),  16'h0);
    chk({tag, "_rgb_b"},  16'(rgb_b),  16'h0);
    chk({tag, "_rbank"},  16'(rb_a),   16'h1);
  endtask

  // One line: start_of_line in cycle T, then cycles T+1..T+642 are checked.
  // wr_k >= 0: palette write of (wa, wd) during cycle T+wr_k.
  // rst_k >= 0: rst asserted during cycle T+rst_k, line abandoned.
  task automatic run_line(input logic sos, input int hs, input logic [7:0] bc,
                          input int wr_k, input logic [7:0] wa, input logic [11:0] wd,
                          input int rst_k);
    bit pend = 0;
    int n;
    hscale = 8'(hs); border_color = bc;
    start_of_line = 1'b1; start_of_screen = sos;
    bank_m  = sos ? 1'b1 : (fresh_m ? 1'b0 : ~bank_m);
    fresh_m = 1'b0;
    tick();
    start_of_line = 1'b0; start_of_screen = 1'b0;
    for (int k = 1; k <= 642; k++) begin
      // a write during cycle w is seen by reads from cycle w+1 on
      if (pend && wr_k < k - 1) begin pal_m[wa] = wd; pend = 0; end
      n = k - 1;
      if (n < 640) begin
        chk($sformatf("addr_a_px%0d", n), 16'(addr_a), 16'({bank_m, 10'(col_of(n, hs))}));
        chk($sformatf("addr_b_px%0d", n), 16'(addr_b), 16'({bank_m, 10'(col_of(n, hs))}));
        chk($sformatf("rbank_px%0d", n),  16'({rb_a, rb_b}), 16'({~bank_m, ~bank_m}));
      end
      n = k - 3;
      if (n >= 0 && n < 640) begin
        chk($sformatf("rgb_a_px%0d", n), 16'(rgb_a), 16'(rgb_of(n, hs, 640, bank_m, bc)));
        chk($sformatf("rgb_b_px%0d", n), 16'(rgb_b), 16'(rgb_of(n, hs, 300, bank_m, bc)));
      end
      if (k == wr_k) begin
        pal_wr_en = 1'b1; pal_wr_addr = wa; pal_wr_data = wd; pend = 1;
      end
      if (k == rst_k) rst = 1'b1;
      tick();
      pal_wr_en = 1'b0;
      if (k == rst_k) begin
        rst = 1'b0;
        chk_reset_state("midline_rst");
        bank_m = 1'b0; fresh_m = 1'b1;
        if (pend) pal_m[wa] = wd;
        return;
      end
    end
    if (pend) pal_m[wa] = wd;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; start_of_line = 1'b0; start_of_screen = 1'b0;
    hscale = 8'd128; border_color = 8'hFF;
    pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
    bank_m = 1'b0; fresh_m = 1'b1;
    for (int c = 0; c < 1024; c++) begin
      lb[c]        = 8'(c);
      lb[1024 + c] = 8'($urandom);
    end
    repeat (3) tick();
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 256; i++) pal_write(8'(i), 12'(i * 16));
    pal_write(8'd5, 12'h123);
    pal_write(8'hFF, 12'hF00);
    repeat (3) tick();
    chk("idle_border_a", 16'(rgb_a), 16'hF00);

    // identity scale from bank 0; pixel 5 is read in cycle T+7 while
    // address 5 is rewritten: old value for pixel 5, new value at pixel 261
    run_line(1'b0, 128, 8'hFF, 7, 8'd5, 12'hABC, -1);
    chk("collision_old", 16'(pal_m[5]), 16'hABC);

    // 2x zoom with border (300-col instance), then bank sequencing
    for (int c = 0; c < 1024; c++) lb[c] = 8'($urandom);
    run_line(1'b1, 64, 8'hFF, -1, 8'd0, 12'd0, -1);
    run_line(1'b0, 64, 8'hFF, -1, 8'd0, 12'd0, -1);
    run_line(1'b0, $urandom_range(0, 255), 8'($urandom), -1, 8'd0, 12'd0, -1);
    run_line(1'b0, $urandom_range(129, 255), 8'($urandom), -1, 8'd0, 12'd0, -1);

    // reset at pixel 200 (its address cycle is T+201)
    run_line(1'b0, 128, 8'hFF, -1, 8'd0, 12'd0, 201);
    repeat (3) tick();
    chk("post_rst_idle_a", 16'(rgb_a), 16'(pal_m[8'hFF]));
    chk("post_rst_idle_b", 16'(rgb_b), 16'(pal_m[8'hFF]));

    for (int i = 0; i < 256; i++) pal_write(8'(i), 12'($urandom));
    run_line(1'b0, $urandom_range(1, 255), 8'($urandom), -1, 8'd0, 12'd0, -1);
    run_line(1'b0, 0, 8'($urandom), 300, 8'($urandom), 12'($urandom), -1);
    run_line(1'b1, $urandom_range(0, 255), 8'($urandom), -1, 8'd0, 12'd0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
